// File: rtl/mlp_dot_chunk_feeder.sv
// Chunked dot-product feeder: streams an input vector and one weight row
// from synchronous memories into SIZE-wide chunks for a run/finished dot unit.
module mlp_dot_chunk_feeder #(
    parameter int TOTAL      = 784,
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start_in,
    input  logic [ADDR_WIDTH-1:0]               weight_base_in,
    input  logic [DATA_WIDTH-1:0]               bias_in,
    output logic                                rd_en_out,
    output logic [ADDR_WIDTH-1:0]               data_addr_out,
    output logic [ADDR_WIDTH-1:0]               weight_addr_out,
    input  logic [DATA_WIDTH-1:0]               data_rd_in,
    input  logic [DATA_WIDTH-1:0]               weight_rd_in,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]     data_chunk_out,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]     weights_chunk_out,
    output logic [DATA_WIDTH-1:0]               bias_chunk_out,
    output logic                                run_out,
    input  logic                                finished_in,
    output logic                                acc_clear_out,
    output logic                                busy_out,
    output logic                                done_out
);

    localparam int NUM_CHUNKS = (TOTAL + SIZE - 1) / SIZE;
    localparam int LW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int EW = $clog2(NUM_CHUNKS * SIZE + 1);

    localparam logic [LW-1:0] LAST_LANE  = LW'(SIZE - 1);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);
    localparam logic [EW-1:0] TOTAL_E    = EW'(TOTAL);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAIN,
        WAIT_LOW,
        FIRE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [EW-1:0]         elem_q;
    logic [LW-1:0]         lane_q;
    logic [CW-1:0]         chunk_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] bias_q;

    logic                  cap_valid_q;
    logic                  cap_rd_q;
    logic [LW-1:0]         cap_lane_q;

    logic [SIZE-1:0][DATA_WIDTH-1:0] data_q;
    logic [SIZE-1:0][DATA_WIDTH-1:0] weights_q;

    logic accept;
    logic in_range;
    logic last_lane;
    logic last_chunk;

    assign accept     = (state_q == IDLE) && start_in;
    assign in_range   = elem_q < TOTAL_E;
    assign last_lane  = lane_q == LAST_LANE;
    assign last_chunk = chunk_q == LAST_CHUNK;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rd_en_out       = 1'b0;
        data_addr_out   = '0;
        weight_addr_out = '0;
        run_out         = 1'b0;
        acc_clear_out   = 1'b0;
        busy_out        = 1'b0;
        done_out        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                busy_out      = 1'b1;
                acc_clear_out = 1'b1;
                state_d       = FETCH;
            end
            FETCH: begin
                busy_out = 1'b1;
                // Padding lanes issue no read; they are zero-filled on capture.
                if (in_range) begin
                    rd_en_out       = 1'b1;
                    data_addr_out   = ADDR_WIDTH'(elem_q);
                    weight_addr_out = base_q + ADDR_WIDTH'(elem_q);
                end
                if (last_lane) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy_out = 1'b1;
                state_d  = WAIT_LOW;
            end
            WAIT_LOW: begin
                busy_out = 1'b1;
                if (!finished_in) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                busy_out = 1'b1;
                run_out  = 1'b1;
                if (finished_in) begin
                    state_d = last_chunk ? DONE : FETCH;
                end
            end
            DONE: begin
                done_out = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elem_q      <= '0;
            lane_q      <= '0;
            chunk_q     <= '0;
            base_q      <= '0;
            bias_q      <= '0;
            cap_valid_q <= 1'b0;
            cap_rd_q    <= 1'b0;
            cap_lane_q  <= '0;
        end else begin
            cap_valid_q <= state_q == FETCH;
            cap_rd_q    <= rd_en_out;
            cap_lane_q  <= lane_q;
            if (accept) begin
                base_q  <= weight_base_in;
                bias_q  <= bias_in;
                elem_q  <= '0;
                lane_q  <= '0;
                chunk_q <= '0;
            end
            if (state_q == FETCH) begin
                elem_q <= elem_q + 1'b1;
                lane_q <= last_lane ? '0 : lane_q + 1'b1;
            end
            if (state_q == FIRE && finished_in && !last_chunk) begin
                chunk_q <= chunk_q + 1'b1;
            end
        end
    end

    // Memory data returns one cycle after the read, so capture trails issue by a lane.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= '0;
            weights_q <= '0;
        end else if (cap_valid_q) begin
            data_q[cap_lane_q]    <= cap_rd_q ? data_rd_in : '0;
            weights_q[cap_lane_q] <= cap_rd_q ? weight_rd_in : '0;
        end
    end

    assign data_chunk_out    = data_q;
    assign weights_chunk_out = weights_q;
    assign bias_chunk_out    = (busy_out && chunk_q == '0) ? bias_q : '0;

endmodule

// File: tb/tb_mlp_dot_chunk_feeder.sv
// Directed bench for mlp_dot_chunk_feeder: two instances (TOTAL=32 and
// TOTAL=20), memory models and a counting dot-unit model.
module tb_mlp_dot_chunk_feeder;

    logic clk;
    logic reset_n;
    logic stuck;

    logic start_a, start_b;
    logic [15:0] base_a, base_b, bias_a, bias_b;
    logic rd_a, rd_b;
    logic [15:0] daddr_a, waddr_a, daddr_b, waddr_b;
    logic [15:0] drd_a, wrd_a, drd_b, wrd_b;
    logic [15:0][15:0] dch_a, wch_a, dch_b, wch_b;
    logic [15:0] bch_a, bch_b;
    logic run_a, run_b, fin_a, fin_b, fin_m_a, fin_m_b;
    logic clr_a, clr_b, busy_a, busy_b, done_a, done_b;

    int vectors = 0;
    int miscompares = 0;

    mlp_dot_chunk_feeder #(.TOTAL(32), .SIZE(16), .DATA_WIDTH(16), .ADDR_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .start_in(start_a),
        .weight_base_in(base_a), .bias_in(bias_a),
        .rd_en_out(rd_a), .data_addr_out(daddr_a), .weight_addr_out(waddr_a),
        .data_rd_in(drd_a), .weight_rd_in(wrd_a),
        .data_chunk_out(dch_a), .weights_chunk_out(wch_a), .bias_chunk_out(bch_a),
        .run_out(run_a), .finished_in(fin_a), .acc_clear_out(clr_a),
        .busy_out(busy_a), .done_out(done_a)
    );

    mlp_dot_chunk_feeder #(.TOTAL(20), .SIZE(16), .DATA_WIDTH(16), .ADDR_WIDTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .start_in(start_b),
        .weight_base_in(base_b), .bias_in(bias_b),
        .rd_en_out(rd_b), .data_addr_out(daddr_b), .weight_addr_out(waddr_b),
        .data_rd_in(drd_b), .weight_rd_in(wrd_b),
        .data_chunk_out(dch_b), .weights_chunk_out(wch_b), .bias_chunk_out(bch_b),
        .run_out(run_b), .finished_in(fin_b), .acc_clear_out(clr_b),
        .busy_out(busy_b), .done_out(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories: data[a] = a+1, weight[a] = a.
    always @(posedge clk) begin
        if (rd_a) begin
            drd_a <= daddr_a + 16'd1;
            wrd_a <= waddr_a;
        end
        if (rd_b) begin
            drd_b <= daddr_b + 16'd1;
            wrd_b <= waddr_b;
        end
    end

    function automatic int dotp(input logic [15:0][15:0] d,
                                input logic [15:0][15:0] w,
                                input logic [15:0] b);
        int s;
        s = int'($signed(b));
        for (int i = 0; i < 16; i++) begin
            s += int'($signed(d[i])) * int'($signed(w[i]));
        end
        return s;
    endfunction

    // Dot-unit model A: finished rises after run has been high 3 cycles.
    int cnt_a = 0, idx_a = 0, runs_a = 0, rdn_a = 0, acc_a = 0;
    int clear_cnt = 0, done_cnt = 0, stab_err = 0, bad_len = 0, wmis = 0, bad_a = 0;
    logic run_prev_a = 1'b0;
    logic [15:0] base_exp;
    logic [15:0][15:0] rec_d_a [2];
    logic [15:0][15:0] rec_w_a [2];
    logic [15:0] rec_b_a [2];
    logic [15:0][15:0] snap_d, snap_w;

    assign fin_a = fin_m_a | stuck;

    always @(negedge clk) begin
        run_prev_a <= run_a;
        cnt_a      <= run_a ? cnt_a + 1 : 0;
        fin_m_a    <= run_a && cnt_a >= 2;
        if (done_a) done_cnt <= done_cnt + 1;
        if (clr_a) begin
            acc_a <= 0;
            idx_a <= 0;
            runs_a <= 0;
            rdn_a <= 0;
            clear_cnt <= clear_cnt + 1;
        end else begin
            if (run_a && !run_prev_a) begin
                if (idx_a < 2) begin
                    rec_d_a[idx_a] <= dch_a;
                    rec_w_a[idx_a] <= wch_a;
                    rec_b_a[idx_a] <= bch_a;
                end
                idx_a  <= idx_a + 1;
                runs_a <= runs_a + 1;
                acc_a  <= acc_a + dotp(dch_a, wch_a, bch_a);
                snap_d <= dch_a;
                snap_w <= wch_a;
            end
            if (run_a && run_prev_a && (dch_a !== snap_d || wch_a !== snap_w))
                stab_err <= stab_err + 1;
            if (!run_a && run_prev_a && cnt_a != 3)
                bad_len <= bad_len + 1;
            if (rd_a) begin
                rdn_a <= rdn_a + 1;
                if (waddr_a !== base_exp + daddr_a) wmis <= wmis + 1;
                if (daddr_a >= 16'd32) bad_a <= bad_a + 1;
            end
        end
    end

    // Dot-unit model B, same handshake.
    int cnt_b = 0, idx_b = 0, runs_b = 0, rdn_b = 0, acc_b = 0, bad_b = 0, done_cnt_b = 0;
    logic run_prev_b = 1'b0;
    logic [15:0][15:0] rec_d_b [2];
    logic [15:0][15:0] rec_w_b [2];
    logic [15:0] rec_b_b [2];

    assign fin_b = fin_m_b;

    always @(negedge clk) begin
        run_prev_b <= run_b;
        cnt_b      <= run_b ? cnt_b + 1 : 0;
        fin_m_b    <= run_b && cnt_b >= 2;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (clr_b) begin
            acc_b <= 0;
            idx_b <= 0;
            runs_b <= 0;
            rdn_b <= 0;
        end else begin
            if (run_b && !run_prev_b) begin
                if (idx_b < 2) begin
                    rec_d_b[idx_b] <= dch_b;
                    rec_w_b[idx_b] <= wch_b;
                    rec_b_b[idx_b] <= bch_b;
                end
                idx_b  <= idx_b + 1;
                runs_b <= runs_b + 1;
                acc_b  <= acc_b + dotp(dch_b, wch_b, bch_b);
            end
            if (rd_b) begin
                rdn_b <= rdn_b + 1;
                if (daddr_b >= 16'd20) bad_b <= bad_b + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0: return done_a;
            1: return run_a;
            2: return rd_a;
            3: return done_b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (probe(sel) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(probe(sel) === lvl), 64'(1));
    endtask

    task automatic go_a(input logic [15:0] base, input logic [15:0] bias);
        base_a  = base;
        bias_a  = bias;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    int done_s, clr_s, wmis_s;

    initial begin
        reset_n = 1'b0;
        stuck = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        base_a = '0; base_b = '0; bias_a = '0; bias_b = '0;
        base_exp = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_a), 64'(0));
        chk("rst_run", 64'(run_a), 64'(0));
        chk("rst_rd", 64'(rd_a), 64'(0));
        chk("rst_clear", 64'(clr_a), 64'(0));
        chk("rst_done", 64'(done_a), 64'(0));
        chk("rst_chunk", 64'(|dch_a), 64'(0));
        chk("rst_bias", 64'(bch_a), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // 1: two chunks, bias on first only
        done_s = done_cnt;
        clr_s = clear_cnt;
        go_a(16'd0, 16'd5);
        chk("s1_clear_hi", 64'(clr_a), 64'(1));
        chk("s1_busy_hi", 64'(busy_a), 64'(1));
        @(negedge clk);
        chk("s1_clear_pulse", 64'(clr_a), 64'(0));
        wait_for(0, 1'b1, 200, "s1_done_seen");
        chk("s1_busy_at_done", 64'(busy_a), 64'(0));
        @(negedge clk);
        chk("s1_done_pulse", 64'(done_a), 64'(0));
        chk("s1_acc", 64'(acc_a), 64'(10917));
        chk("s1_runs", 64'(runs_a), 64'(2));
        chk("s1_reads", 64'(rdn_a), 64'(32));
        chk("s1_c0_l0", 64'(rec_d_a[0][0]), 64'(1));
        chk("s1_c0_l15", 64'(rec_d_a[0][15]), 64'(16));
        chk("s1_c0_bias", 64'(rec_b_a[0]), 64'(5));
        chk("s1_c1_l0", 64'(rec_d_a[1][0]), 64'(17));
        chk("s1_c1_l15", 64'(rec_d_a[1][15]), 64'(32));
        chk("s1_c1_w2", 64'(rec_w_a[1][2]), 64'(18));
        chk("s1_c1_bias", 64'(rec_b_a[1]), 64'(0));
        chk("s1_clears", 64'(clear_cnt - clr_s), 64'(1));
        chk("s1_dones", 64'(done_cnt - done_s), 64'(1));

        // 2: TOTAL=20, second chunk zero-padded
        base_b = 16'd0;
        bias_b = 16'd7;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_for(3, 1'b1, 200, "s2_done_seen");
        @(negedge clk);
        chk("s2_acc", 64'(acc_b), 64'(2667));
        chk("s2_runs", 64'(runs_b), 64'(2));
        chk("s2_reads", 64'(rdn_b), 64'(20));
        chk("s2_oob_reads", 64'(bad_b), 64'(0));
        chk("s2_c0_bias", 64'(rec_b_b[0]), 64'(7));
        chk("s2_c1_bias", 64'(rec_b_b[1]), 64'(0));
        chk("s2_c1_l0", 64'(rec_d_b[1][0]), 64'(17));
        chk("s2_c1_l3", 64'(rec_d_b[1][3]), 64'(20));
        chk("s2_c1_l4", 64'(rec_d_b[1][4]), 64'(0));
        chk("s2_c1_l15", 64'(rec_d_b[1][15]), 64'(0));
        chk("s2_c1_w3", 64'(rec_w_b[1][3]), 64'(19));
        chk("s2_c1_w4", 64'(rec_w_b[1][4]), 64'(0));
        chk("s2_dones", 64'(done_cnt_b), 64'(1));

        // 3: finished stuck high holds the feeder in WAIT_LOW
        go_a(16'd0, 16'd5);
        stuck = 1'b1;
        wait_for(2, 1'b1, 10, "s3_fetch_start");
        wait_for(2, 1'b0, 40, "s3_fetch_end");
        repeat (6) @(negedge clk);
        chk("s3_run_held_low", 64'(run_a), 64'(0));
        chk("s3_still_busy", 64'(busy_a), 64'(1));
        stuck = 1'b0;
        wait_for(1, 1'b1, 4, "s3_run_after_fall");
        wait_for(0, 1'b1, 200, "s3_done_seen");
        @(negedge clk);
        chk("s3_acc", 64'(acc_a), 64'(10917));

        // 4+6: weight base 100, restart attempt mid-chunk ignored
        base_exp = 16'd100;
        wmis_s = wmis;
        done_s = done_cnt;
        go_a(16'd100, 16'd5);
        wait_for(2, 1'b1, 10, "s6_fetch_start");
        chk("s6_waddr0", 64'(waddr_a), 64'(100));
        chk("s6_daddr0", 64'(daddr_a), 64'(0));
        repeat (5) @(negedge clk);
        base_a = 16'd200;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_for(0, 1'b1, 200, "s4_done_seen");
        @(negedge clk);
        chk("s6_acc", 64'(acc_a), 64'(63717));
        chk("s6_waddr_track", 64'(wmis - wmis_s), 64'(0));
        chk("s6_reads", 64'(rdn_a), 64'(32));
        repeat (30) @(negedge clk);
        chk("s4_one_done", 64'(done_cnt - done_s), 64'(1));
        chk("s4_idle_after", 64'(busy_a), 64'(0));
        base_exp = 16'd0;
        chk("run_len", 64'(bad_len), 64'(0));
        chk("chunk_stable", 64'(stab_err), 64'(0));
        chk("a_oob_reads", 64'(bad_a), 64'(0));

        // 5: async reset during FIRE, then a clean restart
        done_s = done_cnt;
        go_a(16'd0, 16'd5);
        wait_for(1, 1'b1, 60, "s5_fire");
        #2 reset_n = 1'b0;
        #1;
        chk("s5_run_async", 64'(run_a), 64'(0));
        chk("s5_busy_async", 64'(busy_a), 64'(0));
        chk("s5_rd_async", 64'(rd_a), 64'(0));
        chk("s5_data_async", 64'(|dch_a), 64'(0));
        chk("s5_wt_async", 64'(|wch_a), 64'(0));
        chk("s5_bias_async", 64'(bch_a), 64'(0));
        @(negedge clk);
        @(negedge clk);
        chk("s5_no_done", 64'(done_cnt - done_s), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        clr_s = clear_cnt;
        go_a(16'd0, 16'd5);
        wait_for(0, 1'b1, 200, "s5_done_seen");
        @(negedge clk);
        chk("s5_acc", 64'(acc_a), 64'(10917));
        chk("s5_runs", 64'(runs_a), 64'(2));
        chk("s5_clears", 64'(clear_cnt - clr_s), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
